// File: rtl/four_bit_priority_encoder.sv
// 4-to-2 priority encoder (highest set bit wins) with two independently coded
// encode paths running in lockstep; any disagreement latches a sticky flag.
module four_bit_priority_encoder #(
  parameter bit REG_OUT  = 1'b1,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] x,
  output logic [1:0] y_comb,
  output logic [1:0] y,
  output logic       valid,
  output logic       mismatch
);

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 2;

  logic [YW-1:0] y_a_c;
  logic          valid_a_c;
  logic [YW-1:0] y_b_raw;
  logic [YW-1:0] y_b_c;
  logic          valid_b_c;

  // Path A: wildcard case table
  always_comb begin
    y_a_c = YW'(0);
    casez (x)
      4'b1???: y_a_c = 2'b11;
      4'b01??: y_a_c = 2'b10;
      4'b001?: y_a_c = 2'b01;
      default: y_a_c = 2'b00;
    endcase
  end

  assign valid_a_c = |x;

  // Path B: explicit priority chain, valid from an independent zero compare
  always_comb begin
    y_b_raw = YW'(0);
    if (x[3])      y_b_raw = 2'b11;
    else if (x[2]) y_b_raw = 2'b10;
    else if (x[1]) y_b_raw = 2'b01;
    else           y_b_raw = 2'b00;
  end

  assign y_b_c     = y_b_raw;
  assign valid_b_c = (x != XW'(0));

  assign y_comb = y_a_c;

  generate
    if (REG_OUT) begin : g_reg_out
      logic [YW-1:0] y_q, y_d;
      logic          valid_q, valid_d;

      always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        if (en) begin
          y_d     = y_a_c;
          valid_d = valid_a_c;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q     <= YW'(0);
          valid_q <= 1'b0;
        end else begin
          y_q     <= y_d;
          valid_q <= valid_d;
        end
      end

      assign y     = y_q;
      assign valid = valid_q;
    end else begin : g_comb_out
      assign y     = y_a_c;
      assign valid = valid_a_c;
    end
  endgenerate

  generate
    if (CHECK_EN) begin : g_check
      logic mismatch_q, mismatch_d;

      // Sticky: once the paths disagree at an edge, hold until reset.
      always_comb begin
        mismatch_d = mismatch_q;
        if ({y_a_c, valid_a_c} != {y_b_c, valid_b_c}) mismatch_d = 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mismatch_q <= 1'b0;
        else        mismatch_q <= mismatch_d;
      end

      assign mismatch = mismatch_q;
    end else begin : g_no_check
      assign mismatch = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_four_bit_priority_encoder.sv
// Scoreboard bench for four_bit_priority_encoder: a driver queues the expected
// post-edge outputs, a monitor pops and compares one entry after each edge.
module tb_four_bit_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] x;
  logic [1:0] y_comb;
  logic [1:0] y;
  logic       valid;
  logic       mismatch;

  four_bit_priority_encoder #(.REG_OUT(1'b1), .CHECK_EN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .x        (x),
    .y_comb   (y_comb),
    .y        (y),
    .valid    (valid),
    .mismatch (mismatch)
  );

  typedef struct {
    logic [1:0] y;
    logic       valid;
    logic       mm;
    logic [1:0] yc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    done   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Reference encode used only for the random section.
  function automatic logic [1:0] model_enc(input logic [3:0] v);
    if (v[3]) return 2'b11;
    if (v[2]) return 2'b10;
    if (v[1]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input logic [3:0] xv, input logic env, input logic [1:0] ey,
                      input logic ev, input logic emm, input logic [1:0] eyc,
                      input string tag);
    exp_t e;
    x  = xv;
    en = env;
    e.y = ey; e.valid = ev; e.mm = emm; e.yc = eyc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: compare one queued expectation just after every rising edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".y"},        {2'b00, y},        {2'b00, e.y});
        chk({t, ".valid"},    {3'b000, valid},   {3'b000, e.valid});
        chk({t, ".mismatch"}, {3'b000, mismatch},{3'b000, e.mm});
        chk({t, ".y_comb"},   {2'b00, y_comb},   {2'b00, e.yc});
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  logic [1:0] tbl [16];
  logic [3:0] rx;
  logic [1:0] ry;

  initial begin
    // Hand-computed priority table for x = 0..15.
    tbl = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
            2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

    rst_n = 1'b0; en = 1'b1; x = 4'b1010;
    #1;
    chk("rst.y",        {2'b00, y},         4'b0000);
    chk("rst.valid",    {3'b000, valid},    4'b0000);
    chk("rst.mismatch", {3'b000, mismatch}, 4'b0000);
    chk("rst.y_comb",   {2'b00, y_comb},    4'b0011);
    @(posedge clk); #1;
    chk("rst_edge.y",     {2'b00, y},      4'b0000);
    chk("rst_edge.valid", {3'b000, valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep with en=1.
    for (int i = 0; i < 16; i++) begin
      tick();
      step(4'(i), 1'b1, tbl[i], (i != 0), 1'b0, tbl[i], $sformatf("sweep%0d", i));
    end

    // Zero versus bit0.
    tick(); step(4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, "zero");
    tick(); step(4'b0001, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, "bit0");

    // Enable hold.
    tick(); step(4'b1000, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, "hold_load");
    for (int i = 0; i < 3; i++) begin
      tick(); step(4'b0010, 1'b0, 2'b11, 1'b1, 1'b0, 2'b01, $sformatf("hold%0d", i));
    end

    // Random vectors with en=1.
    for (int i = 0; i < 99; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = model_enc(rx);
      tick(); step(rx, 1'b1, ry, |rx, 1'b0, ry, $sformatf("rand%0d", i));
    end

    // Async reset between edges with y=11, valid=1.
    tick(); step(4'b1000, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, "pre_rst");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.y",      {2'b00, y},       4'b0000);
    chk("async_rst.valid",  {3'b000, valid},  4'b0000);
    chk("async_rst.y_comb", {2'b00, y_comb},  4'b0011);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); step(4'b0100, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, "post_rst");

    // Force path B to disagree for one edge; mismatch must stick.
    tick(); step(4'b1000, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, "force");
    force dut.y_b_c = 2'b01;
    tick();
    release dut.y_b_c;
    step(4'b0010, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, "sticky0");
    tick(); step(4'b0100, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, "sticky1");
    tick(); step(4'b0000, 1'b1, 2'b00, 1'b0, 1'b1, 2'b00, "sticky2");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mm_rst.mismatch", {3'b000, mismatch}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); step(4'b0110, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10, "mm_clear");

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 4'(exp_q.size()), 4'd0);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_bit_priority_encoder.md
Name: four_bit_priority_encoder

Overview:
- 4-to-2 priority encoder. The highest set input bit wins.
- Two independently coded encode paths run in lockstep:
  - path A: case/casez-style;
  - path B: if/else-priority-chain style.
- The primary output comes from path A, combinationally and as a registered copy.
- Any disagreement between the paths sets a sticky error flag.
- Used as a leaf decode block wherever a 4-bit request/flag vector is reduced to an index.

Parameters:
- REG_OUT, 1, when 1, y/valid are registered (1-cycle latency); when 0, y/valid equal the combinational path A result.
- CHECK_EN, 1, when 1, the path A vs path B lockstep compare drives mismatch; when 0, mismatch is tied 0.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable for the registered outputs.
- x  in  4  input vector to encode.
- y_comb  out  2  combinational encode of x (path A), no clock involvement.
- y  out  2  encoded index (registered when REG_OUT=1).
- valid  out  1  1 when the encoded x was nonzero.
- mismatch  out  1  sticky flag: path A and path B results differed.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Encode function, identical in both paths:
  - x[3]=1 -> 2'b11, regardless of lower bits.
  - else x[2]=1 -> 2'b10.
  - else x[1]=1 -> 2'b01.
  - else x[0]=1 -> 2'b00.
  - x=4'b0000 -> 2'b00 with valid=0.
- All 16 input codes are defined. There are no X/don't-care outputs for non-one-hot inputs. Both paths must produce bit-identical results for every input.
- valid_comb = |x.
- y_comb follows x with zero cycles of latency and is independent of clk, rst_n and en.
- REG_OUT=1:
  - On the rising clk edge with en=1: y <= enc(x), valid <= |x.
  - With en=0: y and valid hold.
  - Latency is exactly one clock from x/en sampled to y/valid.
- REG_OUT=0: y = y_comb and valid = |x; en is ignored.
- mismatch (CHECK_EN=1):
  - Evaluated every rising clk edge, independent of en.
  - Set when path A != path B.
  - Once set, stays 1 until rst_n is asserted.
  - Is never 0 while a disagreement is present at an edge.
- Reset (rst_n=0):
  - Immediately, without waiting for a clock: y=2'b00, valid=0, mismatch=0.
  - y_comb is unaffected.
  - Reset mid-operation discards the registered value.
  - The first sample after release occurs on the first rising edge with rst_n=1 and en=1.
- Simultaneous en=1 and rst_n=0: reset wins.
- No internal state other than y, valid and mismatch.

Test Plan:
- Exhaustive compare: drive x = 0..15, 10 time units each -> y_comb matches the priority table at every step, e.g. 4'b1010 -> 11, 4'b0110 -> 10, 4'b0011 -> 01, 4'b0001 -> 00, 4'b0000 -> 00; mismatch stays 0.
- Random: 99 random x values, each held 10 time units, with en=1 -> y equals enc of the previous-cycle x and valid equals |(previous x); mismatch=0 throughout.
- Zero vs bit0: x=4'b0000 then 4'b0001, en=1 -> y=00 for both; valid=0 then 1.
- Enable hold: load x=4'b1000 (y=11, valid=1), then en=0 and x=4'b0010 for 3 cycles -> y stays 11, valid stays 1, y_comb=01.
- Async reset: with y=11 and valid=1, pull rst_n low between edges -> y=00 and valid=0 immediately. Release, then x=4'b0100, en=1 -> y=10 after one edge.
- Mismatch path: force path B output to differ for one edge (bench force) -> mismatch=1 and remains 1 after the force is released, until rst_n=0.
